morse_key_decoder: RTL and testbench



---
 rtl/morse_pkg.sv | 28 ++
 rtl/morse_key_decoder_if.sv | 19 +
 rtl/morse_lut.sv | 64 ++++++
 rtl/morse_key_decoder.sv | 196 +++++++++++++++++++
 tb/tb_morse_key_decoder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared encodings and timing multipliers for the Morse key decoder.
// All durations are multiples of one Morse time unit (a dot length).
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_SPACE = 3'd2,
    S_EMIT  = 3'd3,
    S_WGAP  = 3'd4
  } state_t;

  localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  localparam int DOT_MAX_U    = 2;
  localparam int LETTER_GAP_U = 2;
  localparam int WORD_GAP_U   = 5;
  localparam int SAT_U        = 8;

  // A letter longer than five symbols cannot be a valid code.
  localparam logic [2:0] SYM_LEN_MAX = 3'd6;

  function automatic logic [2:0] sym_len_inc(input logic [2:0] len);
    return (len >= SYM_LEN_MAX) ? SYM_LEN_MAX : len + 3'd1;
  endfunction

endpackage

// File: rtl/morse_key_decoder_if.sv
// Character handoff from the Morse decoder to the LCD writer.
// A character is delivered on any clock edge where char_valid && char_ready.
interface morse_key_decoder_if;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_data;

  modport master (
    output char_valid,
    output char_data,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_data,
    output char_ready
  );
endinterface

// File: rtl/morse_lut.sv
// Combinational ITU Morse translation: pattern holds the symbols right-aligned,
// first symbol at bit len-1, dot=0 / dash=1. Unmapped codes give '?'.
module morse_lut
  import morse_pkg::*;
(
  input  logic [4:0] pattern,
  input  logic [2:0] len,
  output logic [7:0] ascii
);

  logic [4:0] mask;
  logic [7:0] code_key;

  // Bits above the letter length are ignored so stale history never aliases.
  for (genvar gi = 0; gi < 5; gi++) begin : g_mask
    assign mask[gi] = (len > 3'(gi));
  end

  assign code_key = {len, pattern & mask};

  always_comb begin
    ascii = CHAR_UNKNOWN;
    case (code_key)
      {3'd1, 5'b00000}: ascii = "E";
      {3'd1, 5'b00001}: ascii = "T";
      {3'd2, 5'b00000}: ascii = "I";
      {3'd2, 5'b00001}: ascii = "A";
      {3'd2, 5'b00010}: ascii = "N";
      {3'd2, 5'b00011}: ascii = "M";
      {3'd3, 5'b00000}: ascii = "S";
      {3'd3, 5'b00001}: ascii = "U";
      {3'd3, 5'b00010}: ascii = "R";
      {3'd3, 5'b00011}: ascii = "W";
      {3'd3, 5'b00100}: ascii = "D";
      {3'd3, 5'b00101}: ascii = "K";
      {3'd3, 5'b00110}: ascii = "G";
      {3'd3, 5'b00111}: ascii = "O";
      {3'd4, 5'b00000}: ascii = "H";
      {3'd4, 5'b00001}: ascii = "V";
      {3'd4, 5'b00010}: ascii = "F";
      {3'd4, 5'b00100}: ascii = "L";
      {3'd4, 5'b00110}: ascii = "P";
      {3'd4, 5'b00111}: ascii = "J";
      {3'd4, 5'b01000}: ascii = "B";
      {3'd4, 5'b01001}: ascii = "X";
      {3'd4, 5'b01010}: ascii = "C";
      {3'd4, 5'b01011}: ascii = "Y";
      {3'd4, 5'b01100}: ascii = "Z";
      {3'd4, 5'b01101}: ascii = "Q";
      {3'd5, 5'b00000}: ascii = "5";
      {3'd5, 5'b00001}: ascii = "4";
      {3'd5, 5'b00011}: ascii = "3";
      {3'd5, 5'b00111}: ascii = "2";
      {3'd5, 5'b01111}: ascii = "1";
      {3'd5, 5'b10000}: ascii = "6";
      {3'd5, 5'b11000}: ascii = "7";
      {3'd5, 5'b11100}: ascii = "8";
      {3'd5, 5'b11110}: ascii = "9";
      {3'd5, 5'b11111}: ascii = "0";
      default:          ascii = CHAR_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key front end: synchronise and debounce the key, time marks and gaps,
// assemble each letter and hand the decoded ASCII to the LCD writer.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int UNIT_MS     = 100,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_in,
  morse_key_decoder_if.master        chr,
  output logic                       busy,
  output logic [2:0]                 sym_len,
  output logic                       err_overflow
);

  localparam int UNIT_CYC = CLK_FREQ / 1000 * UNIT_MS;
  localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;

  localparam logic [31:0] DB_LAST     = 32'((DB_CYC > 0) ? DB_CYC - 1 : 0);
  localparam logic [31:0] DOT_MAX_CYC = 32'(DOT_MAX_U * UNIT_CYC);
  localparam logic [31:0] LETTER_CYC  = 32'(LETTER_GAP_U * UNIT_CYC);
  localparam logic [31:0] WORD_CYC    = 32'(WORD_GAP_U * UNIT_CYC);
  localparam logic [31:0] SAT_CYC     = 32'(SAT_U * UNIT_CYC);

  logic [1:0]  sync_reg;
  logic        key_sync;
  logic        key_db_reg;
  logic [31:0] db_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], key_in};
    end
  end

  assign key_sync = sync_reg[1];

  // key_db follows the synchronised key only after DB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db_reg <= 1'b0;
      db_cnt_reg <= '0;
    end else if (key_sync != key_db_reg) begin
      if (db_cnt_reg >= DB_LAST) begin
        key_db_reg <= key_sync;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 32'd1;
      end
    end else begin
      db_cnt_reg <= '0;
    end
  end

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next, cnt_inc;
  logic [4:0]  pattern_reg, pattern_next;
  logic [2:0]  sym_len_reg, sym_len_next;
  logic        lsp_reg, lsp_next;
  logic        char_valid_reg, char_valid_next;
  logic [7:0]  char_data_reg, char_data_next;
  logic        err_reg, err_next;
  logic        issue;
  logic [7:0]  issue_data;
  logic        delivered;
  logic [7:0]  lut_ascii;

  morse_lut u_lut (
    .pattern (pattern_reg),
    .len     (sym_len_reg),
    .ascii   (lut_ascii)
  );

  assign cnt_inc   = (cnt_reg >= SAT_CYC) ? cnt_reg : cnt_reg + 32'd1;
  assign delivered = char_valid_reg && chr.char_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      pattern_reg    <= '0;
      sym_len_reg    <= '0;
      lsp_reg        <= 1'b0;
      char_valid_reg <= 1'b0;
      char_data_reg  <= 8'h00;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pattern_reg    <= pattern_next;
      sym_len_reg    <= sym_len_next;
      lsp_reg        <= lsp_next;
      char_valid_reg <= char_valid_next;
      char_data_reg  <= char_data_next;
      err_reg        <= err_next;
    end
  end

  // The edge cycle that enters MARK or SPACE is itself the first counted cycle,
  // so a count of N means the key has held its level for N cycles.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pattern_next    = pattern_reg;
    sym_len_next    = sym_len_reg;
    lsp_next        = lsp_reg;
    issue           = 1'b0;
    issue_data      = lut_ascii;
    char_valid_next = char_valid_reg;
    char_data_next  = char_data_reg;
    err_next        = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (key_db_reg) begin
          state_next = S_MARK;
          cnt_next   = 32'd1;
        end
      end
      S_MARK: begin
        if (key_db_reg) begin
          cnt_next = cnt_inc;
        end else begin
          pattern_next = {pattern_reg[3:0], (cnt_reg >= DOT_MAX_CYC)};
          sym_len_next = sym_len_inc(sym_len_reg);
          state_next   = S_SPACE;
          cnt_next     = 32'd1;
        end
      end
      S_SPACE: begin
        if (key_db_reg) begin
          state_next = S_MARK;
          cnt_next   = 32'd1;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= LETTER_CYC) begin
            state_next = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        issue        = 1'b1;
        issue_data   = lut_ascii;
        pattern_next = '0;
        sym_len_next = '0;
        lsp_next     = 1'b1;
        cnt_next     = cnt_inc;
        state_next   = S_WGAP;
      end
      S_WGAP: begin
        if (key_db_reg) begin
          state_next = S_MARK;
          cnt_next   = 32'd1;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= WORD_CYC) begin
            issue      = lsp_reg;
            issue_data = CHAR_SPACE;
            lsp_next   = 1'b0;
            cnt_next   = '0;
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    if (delivered) begin
      char_valid_next = 1'b0;
    end
    // A slot freed by a delivery this cycle can take the new character at once.
    if (issue) begin
      if (!char_valid_reg || delivered) begin
        char_valid_next = 1'b1;
        char_data_next  = issue_data;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  assign chr.char_valid = char_valid_reg;
  assign chr.char_data  = char_data_reg;
  assign busy           = (sym_len_reg != 3'd0);
  assign sym_len        = sym_len_reg;
  assign err_overflow   = err_reg;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed and randomized checks of the Morse key decoder against a
// duration-based reference model (dot/dash and gap classes from key timings).
module tb_morse_key_decoder;

  localparam int UNIT = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic       busy;
  logic [2:0] sym_len;
  logic       err_overflow;

  morse_key_decoder_if chr();

  morse_key_decoder #(
    .CLK_FREQ    (1000),
    .UNIT_MS     (100),
    .DEBOUNCE_MS (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .chr          (chr),
    .busy         (busy),
    .sym_len      (sym_len),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];
  int         pr_q[$];
  int         gp_q[$];

  string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};

  always @(negedge clk) begin
    if (rst_n && chr.char_valid && chr.char_ready) begin
      got_q.push_back(chr.char_data);
      got_t.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int d);
    key_in = 1'b1;
    step(d);
    key_in = 1'b0;
  endtask

  function automatic logic [7:0] decode(input string s);
    if (s.len() > 5) return 8'h3F;
    for (int i = 0; i < 36; i++) begin
      if (codes[i] == s) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
    end
    return 8'h3F;
  endfunction

  // Expected characters straight from mark/gap durations.
  function automatic void predict();
    string letter = "";
    bit since_space = 1'b0;
    for (int i = 0; i < pr_q.size(); i++) begin
      if (pr_q[i] < 2 * UNIT) letter = {letter, "."};
      else letter = {letter, "-"};
      if (gp_q[i] >= 2 * UNIT) begin
        exp_q.push_back(decode(letter));
        letter = "";
        since_space = 1'b1;
        if (gp_q[i] >= 5 * UNIT && since_space) begin
          exp_q.push_back(8'h20);
          since_space = 1'b0;
        end
      end
    end
  endfunction

  task automatic play();
    for (int i = 0; i < pr_q.size(); i++) begin
      press(pr_q[i]);
      step(gp_q[i]);
    end
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_char%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0;
    int w;
    string sym;

    chr.char_ready = 1'b1;
    step(3);
    check("rst_valid", 32'(chr.char_valid), 32'd0);
    check("rst_data", 32'(chr.char_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sym_len", 32'(sym_len), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    rst_n = 1'b1;
    step(5);

    // Single dot: 'E', then one space at the word gap, nothing afterwards.
    pr_q = {100};
    gp_q = {700};
    predict();
    press(100);
    t0 = cyc;
    step(700);
    check("lat_E", (got_t.size() > 0) ? 32'(got_t[0] - t0) : 32'hFFFF_FFFF, 32'd213);
    check("lat_space", (got_t.size() > 1) ? 32'(got_t[1] - t0) : 32'hFFFF_FFFF, 32'd512);
    compare_q("E");
    step(1000);
    check("no_double_space", 32'(got_q.size()), 32'd0);

    // 'A' with sym_len observed during assembly.
    pr_q = {100, 300};
    gp_q = {100, 700};
    predict();
    press(100);
    step(50);
    check("A_sym_len1", 32'(sym_len), 32'd1);
    step(50);
    press(300);
    step(100);
    check("A_sym_len2", 32'(sym_len), 32'd2);
    check("A_busy", 32'(busy), 32'd1);
    step(200);
    check("A_sym_len0", 32'(sym_len), 32'd0);
    check("A_idle", 32'(busy), 32'd0);
    step(400);
    compare_q("A");

    // Seven symbols: sym_len saturates at 6, letter decodes to '?'.
    pr_q = {300, 100, 100, 300, 100, 100, 100};
    gp_q = {100, 100, 100, 100, 100, 100, 700};
    predict();
    for (int i = 0; i < 6; i++) begin
      press(pr_q[i]);
      step(gp_q[i]);
    end
    press(pr_q[6]);
    step(100);
    check("unk_sym_len_sat", 32'(sym_len), 32'd6);
    step(600);
    compare_q("unk");

    // Glitches shorter than the debounce window.
    for (int i = 0; i < 6; i++) begin
      press(5);
      step(20);
    end
    step(300);
    check("glitch_sym_len", 32'(sym_len), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_valid", 32'(chr.char_valid), 32'd0);
    check("glitch_none", 32'(got_q.size()), 32'd0);

    // Random letters, mixed letter and word gaps.
    pr_q.delete();
    gp_q.delete();
    for (int l = 0; l < 10; l++) begin
      if ($urandom_range(0, 4) == 0) begin
        sym = "";
        for (int j = 0; j < 6; j++) begin
          if ($urandom_range(0, 1) == 1) sym = {sym, "-"};
          else sym = {sym, "."};
        end
      end else begin
        sym = codes[$urandom_range(0, 35)];
      end
      for (int j = 0; j < sym.len(); j++) begin
        if (sym[j] == "-") pr_q.push_back(int'($urandom_range(240, 450)));
        else pr_q.push_back(int'($urandom_range(40, 160)));
        if (j < sym.len() - 1) gp_q.push_back(int'($urandom_range(40, 160)));
        else if (l == 9) gp_q.push_back(700);
        else if ($urandom_range(0, 2) == 0) gp_q.push_back(int'($urandom_range(560, 700)));
        else gp_q.push_back(int'($urandom_range(240, 440)));
      end
    end
    predict();
    play();
    compare_q("rnd");

    // Backpressure: 'E' held, the space and 'T' are dropped.
    chr.char_ready = 1'b0;
    pr_q = {100, 300};
    gp_q = {700, 700};
    play();
    check("bp_valid", 32'(chr.char_valid), 32'd1);
    check("bp_data", 32'(chr.char_data), 32'h45);
    check("bp_err", 32'(err_overflow), 32'd1);
    check("bp_none", 32'(got_q.size()), 32'd0);
    chr.char_ready = 1'b1;
    step(2);
    exp_q = {8'h45};
    compare_q("bp");
    check("bp_drained", 32'(chr.char_valid), 32'd0);
    check("bp_err_sticky", 32'(err_overflow), 32'd1);

    // Reset in the middle of a letter.
    press(100);
    step(100);
    press(100);
    step(50);
    check("mid_sym_len", 32'(sym_len), 32'd2);
    rst_n = 1'b0;
    #2;
    check("mid_rst_sym_len", 32'(sym_len), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(chr.char_valid), 32'd0);
    check("mid_rst_data", 32'(chr.char_data), 32'h00);
    check("mid_rst_err", 32'(err_overflow), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(5);

    // Reset while a character is pending.
    chr.char_ready = 1'b0;
    press(100);
    w = 0;
    while (!chr.char_valid && w < 400) begin
      step(1);
      w++;
    end
    check("hs_valid_before", 32'(chr.char_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    check("hs_rst_valid", 32'(chr.char_valid), 32'd0);
    check("hs_rst_data", 32'(chr.char_data), 32'h00);
    step(3);
    rst_n = 1'b1;
    chr.char_ready = 1'b1;
    step(700);
    check("hs_no_delivery", 32'(got_q.size()), 32'd0);

    // Normal decode after reset: 'E', ' ', 'T', ' '.
    pr_q = {100, 300};
    gp_q = {600, 700};
    predict();
    play();
    compare_q("ET");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
